dadda_cpa_seq: RTL and testbench



---
 rtl/dadda_pkg.sv | 33 +++
 rtl/csa_dadda.sv | 19 +
 rtl/dadda_cpa_chunk.sv | 36 +++
 rtl/dadda_cpa_seq.sv | 157 +++++++++++++++
 tb/tb_dadda_cpa_seq.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dadda_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dadda_pkg
// Description : Shared state encoding and sizing helpers for the Dadda
//               final carry-propagate stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dadda_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index width, never below one bit so NCHUNK == 1 still has a legal counter.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csa_dadda.sv
`default_nettype none
// ============================================================================
// Module      : csa_dadda
// Description : Single-bit full-adder cell shared with the reduction tree.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_dadda (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/dadda_cpa_chunk.sv
`default_nettype none
// ============================================================================
// Module      : dadda_cpa_chunk
// Description : Combinational CHUNK-bit ripple adder built from csa_dadda cells.
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_cpa_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa
            csa_dadda u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (w_c[i]),
                .s  (sum[i]),
                .co (w_c[i+1])
            );
        end
    endgenerate

    assign cout = w_c[CHUNK];

endmodule
`default_nettype wire

// File: rtl/dadda_cpa_seq.sv
`default_nettype none
// ============================================================================
// Module      : dadda_cpa_seq
// Description : Multi-cycle carry-propagate adder for the two residual Dadda
//               rows; adds CHUNK bits per cycle with one reused adder slice.
//               Define DADDA_CPA_OVF_EN to expose the MSB carry-out on cout.
// Revision    : 1.0 - initial release
// ============================================================================
module dadda_cpa_seq
    import dadda_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_s,
    input  logic [WIDTH-1:0] row_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod
`ifdef DADDA_CPA_OVF_EN
    ,
    output logic             cout
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = clog2_min1(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] prod_q, prod_d;
`ifdef DADDA_CPA_OVF_EN
    logic             cout_q, cout_d;
`endif

    logic [CHUNK-1:0] w_a, w_b, w_sum;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (state_q == ST_ADD) && (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept)  state_d = ST_ADD;
            ST_ADD:  if (w_last)    state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; in_ready is masked by rst so nothing is taken during reset.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                w_a = s_q[k*CHUNK +: CHUNK];
                w_b = c_q[k*CHUNK +: CHUNK];
            end
        end
    end

    dadda_cpa_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (w_a),
        .b    (w_b),
        .cin  (carry_q),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        s_d     = s_q;
        c_d     = c_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        prod_d  = prod_q;
`ifdef DADDA_CPA_OVF_EN
        cout_d  = cout_q;
`endif
        if (w_accept) begin
            s_d     = row_s;
            c_d     = row_c;
            idx_d   = '0;
            carry_d = 1'b0;
        end else if (state_q == ST_ADD) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    prod_d[k*CHUNK +: CHUNK] = w_sum;
                end
            end
            carry_d = w_cout;
            idx_d   = w_last ? '0 : idx_q + 1'b1;
`ifdef DADDA_CPA_OVF_EN
            if (w_last) begin
                cout_d = w_cout;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            prod_q  <= '0;
`ifdef DADDA_CPA_OVF_EN
            cout_q  <= 1'b0;
`endif
        end else begin
            s_q     <= s_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            prod_q  <= prod_d;
`ifdef DADDA_CPA_OVF_EN
            cout_q  <= cout_d;
`endif
        end
    end

    assign prod = prod_q;
`ifdef DADDA_CPA_OVF_EN
    assign cout = cout_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dadda_cpa_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dadda_cpa_seq
// Description : Self-checking bench for dadda_cpa_seq (WIDTH=16, CHUNK=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dadda_cpa_seq;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] row_s;
    logic [WIDTH-1:0] row_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] prod;
`ifdef DADDA_CPA_OVF_EN
    logic             cout;
`endif

    dadda_cpa_seq #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_s     (row_s),
        .row_c     (row_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod)
`ifdef DADDA_CPA_OVF_EN
        ,
        .cout      (cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] p;
        logic             co;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] p;
        logic             co;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[8];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   nout = 0;
    bit   have_acc = 1'b0;
    bit   acc_flag = 1'b0;
    bit   b2b_mode = 1'b0;
    bit   seen_ov = 1'b0;
    logic [WIDTH-1:0] pend_prod;
    logic             pend_cout;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Observes the handshakes at the falling edge, ahead of the rising edge they take effect on.
    task automatic sample();
        exp_t e;
        cyc++;
        if (rst) begin
            sbq.delete();
            seen_ov  = 1'b0;
            have_acc = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sbq.push_back('{p: pend_prod, co: pend_cout});
                if (b2b_mode && have_acc) begin
                    check("b2b_gap", cyc - acc_cyc, NCHUNK + 2);
                end
                acc_cyc  = cyc;
                have_acc = 1'b1;
                acc_flag = 1'b1;
            end
            // Accept edge T is seen one sample before it; edge T+NCHUNK is NCHUNK+1 samples later.
            if (out_valid && !seen_ov) begin
                check("latency", cyc - acc_cyc, NCHUNK + 1);
                check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
            end
            seen_ov = out_valid;
            if (out_valid && out_ready) begin
                nout++;
                if (sbq.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("prod", {16'd0, prod}, {16'd0, e.p});
`ifdef DADDA_CPA_OVF_EN
                    check("cout", {31'd0, cout}, {31'd0, e.co});
`endif
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                        input logic [WIDTH-1:0] p, input logic co);
        row_s     = s;
        row_c     = c;
        pend_prod = p;
        pend_cout = co;
        in_valid  = 1'b1;
        acc_flag  = 1'b0;
        for (int i = 0; i < 40 && !acc_flag; i++) begin
            step();
        end
        if (!acc_flag) begin
            check("accept_timeout", 32'd1, 32'd0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) begin
            step();
        end
        check("drain_timeout", sbq.size(), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] s, c, p;
        logic             co;
        int               n0;
        int               ov_cnt;

        vecs[0] = '{s: 16'h00FF, c: 16'h0001, p: 16'h0100, co: 1'b0};
        vecs[1] = '{s: 16'hFFFF, c: 16'h0001, p: 16'h0000, co: 1'b1};
        vecs[2] = '{s: 16'h1234, c: 16'h4321, p: 16'h5555, co: 1'b0};
        vecs[3] = '{s: 16'h0003, c: 16'h0004, p: 16'h0007, co: 1'b0};
        vecs[4] = '{s: 16'h8000, c: 16'h8000, p: 16'h0000, co: 1'b1};
        vecs[5] = '{s: 16'hAAAA, c: 16'h5555, p: 16'hFFFF, co: 1'b0};
        vecs[6] = '{s: 16'h7FFF, c: 16'h0001, p: 16'h8000, co: 1'b0};
        vecs[7] = '{s: 16'h0F0F, c: 16'hF0F1, p: 16'h0000, co: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        row_s     = '0;
        row_c     = '0;
        pend_prod = '0;
        pend_cout = 1'b0;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_prod", {16'd0, prod}, 32'd0);
`ifdef DADDA_CPA_OVF_EN
        check("rst_cout", {31'd0, cout}, 32'd0);
`endif
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Table vectors, one at a time
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].s, vecs[i].c, vecs[i].p, vecs[i].co);
            in_valid = 1'b0;
            drain();
        end

        // Backpressure in DONE
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 16'h5555, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            step();
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_prod", {16'd0, prod}, 32'h5555);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_sb_empty", sbq.size(), 32'd0);

        // Reset in the second ADD cycle
        send(16'h1111, 16'h2222, 16'h3333, 1'b0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_prod", {16'd0, prod}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        ov_cnt = 0;
        for (int i = 0; i < NCHUNK + 4; i++) begin
            step();
            if (out_valid) ov_cnt++;
        end
        check("mid_rst_no_valid", ov_cnt, 32'd0);
        send(16'h0003, 16'h0004, 16'h0007, 1'b0);
        in_valid = 1'b0;
        drain();

        // in_valid and row changes during ADD and DONE are ignored
        out_ready = 1'b0;
        send(16'h00FF, 16'h0001, 16'h0100, 1'b0);
        pend_prod = 16'hDEAD;
        pend_cout = 1'b1;
        for (int i = 0; i < NCHUNK + 3; i++) begin
            row_s    = WIDTH'($urandom);
            row_c    = WIDTH'($urandom);
            in_valid = i[0];
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n0 = nout;
        drain();
        for (int i = 0; i < NCHUNK + 4; i++) begin
            step();
        end
        check("ignored_single_result", nout - n0, 32'd1);

        // Back-to-back randomised sweep with in_valid held high
        b2b_mode = 1'b1;
        have_acc = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            s = WIDTH'($urandom);
            c = WIDTH'($urandom);
            {co, p} = {1'b0, s} + {1'b0, c};
            send(s, c, p, co);
        end
        in_valid = 1'b0;
        drain();
        b2b_mode = 1'b0;

        check("final_sb_empty", sbq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
